sevenseg_bcd_display: RTL and testbench
=======================================

// Module: sevenseg_bcd_display
// PURPOSE
//  Downstream display stage for the board ALU/CPU top levels.
//  - Accepts a 32-bit result word through a valid/ready handshake.
//  - Converts it to BCD sequentially (double-dabble, one bit per cycle), replacing wide combinational divide/modulo chains.
//  - Drives the 8-digit multiplexed seven-segment display (AN, CA..CG) with leading-zero blanking and a minus sign.
// PARAMETERS
//  SCAN_DIV  1000  clock cycles each digit stays lit (>=2)
//  SIGNED    1     1: value_i is two's complement; 0: value_i is unsigned
// PORTS
//  CLK100   in   1   system clock; single clock domain
//  resetn   in   1   synchronous, active-low reset
//  value_i  in   32  word to display
//  valid_i  in   1   conversion request
//  ready_o  out  1   converter idle; value_i is accepted when valid_i && ready_o
//  AN       out  8   digit anodes, active low, AN[0] = rightmost digit
//  SEG      out  7   {CA,CB,CC,CD,CE,CF,CG}, active low
//  DP       out  1   decimal point, active low; constant 1 (off)
// BEHAVIOUR
//  Reset (resetn=0 at a CLK100 edge)
//  - AN=8'hFF, SEG=7'h7F, DP=1, ready_o=1.
//  - FSM goes to IDLE, scan counter=0, digit index=0.
//  - Display register is loaded with value 0.
//  - Reset mid-conversion aborts the conversion; the captured value is discarded.
//  Converter FSM (IDLE -> CONV -> DONE -> IDLE)
//  - IDLE: ready_o=1. On valid_i at edge T:
//    - capture mag = (SIGNED && value_i[31]) ? -value_i : value_i, as 32-bit unsigned;
//    - capture neg = SIGNED && value_i[31];
//    - clear the 40-bit BCD accumulator and go to CONV.
//    - ready_o=0 from T+1.
//  - CONV: at edges T+1..T+32, one iteration per edge:
//    - add 3 to every BCD nibble >= 5;
//    - then shift {bcd, mag} left by 1.
//    - valid_i is ignored. An iteration counter 0..31 selects DONE after the 32nd shift.
//  - DONE, edge T+33:
//    - load the display register (8 glyph codes) from bcd and neg;
//    - return to IDLE; ready_o=1 from T+34.
//  Glyph formation (loaded in DONE)
//  - n = index of the most significant non-zero BCD digit; n = 0 if the value is zero.
//  - Digit 0 always shows; digits 1..n show their numeral; higher digits are blank.
//  - If neg, digit n+1 shows minus (SEG=7'b1111110).
//  - Overflow: all 8 digits show minus when either holds:
//    - !neg and mag >= 100000000;
//    - neg and mag >= 10000000.
//    - This includes 32'h80000000 when SIGNED=1.
//  Segment codes (SEG, active low)
//   0:0000001  1:1001111  2:0010010  3:0000110  4:1001100
//   5:0100100  6:0100000  7:0001111  8:0000000  9:0000100  blank:1111111
//  Scan
//  - Free-running counter 0..SCAN_DIV-1. At the edge where counter==SCAN_DIV-1: counter<=0, idx<=idx+1 (mod 8).
//  - AN and SEG are registered from the same idx on the same edge:
//    - AN = ~(8'b1 << idx);
//    - SEG = glyph[idx].
//    - No cycle exists where AN and SEG disagree.
//  - First edge after reset release: AN=8'hFE, SEG=code of digit 0.
//  - A display register update in DONE appears on the next edge at the currently selected digit. The scan is not restarted.
// TESTING
//  1. Hold resetn=0 for 3 cycles -> AN=FF, SEG=7F, ready_o=1. After release: idx0 SEG=0000001, idx1..7 SEG=1111111.
//  2. SIGNED=1, value_i=1234 pulsed with valid_i -> ready_o low 33 cycles. Then idx0..3 = 4,3,2,1; idx4..7 blank.
//  3. value_i=32'hFFFFFFFB -> idx0 '5' (0100100), idx1 minus (1111110), idx2..7 blank.
//  4. value_i=32'h80000000 -> all idx minus. SIGNED=0 with value_i=100000000 -> all minus. SIGNED=0 with 99999999 -> all '9'.
//  5. valid_i held high with value changing 7 -> 9 during CONV -> '7' displayed. The next value is accepted only on the edge after ready_o rises.
//  6. SCAN_DIV=4 -> AN steps FE,FD,FB,F7,EF,DF,BF,7F,FE, each held 4 cycles. resetn pulsed low mid-CONV -> ready_o=1 and display "0".

Source files
------------

// File: rtl/sevenseg_bcd_display.sv
// Converts a 32-bit result word to decimal and scans it onto an 8-digit seven-segment display.
// Latency: value accepted at edge T, display register loaded at T+33, first visible on the next scan edge.
// Backpressure: ready_o is low from acceptance until the glyphs are loaded; valid_i is ignored while busy.
module sevenseg_bcd_display #(
    parameter int SCAN_DIV = 1000,
    parameter bit SIGNED   = 1'b1
) (
    input  logic        CLK100,
    input  logic        resetn,
    input  logic [31:0] value_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [6:0] SEG_MINUS = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b0000001;

    // Map one BCD digit to its active-low segment pattern; non-decimal codes blank.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Converter state
    logic [1:0]  state;
    logic [4:0]  iter;
    logic [31:0] mag;
    logic [39:0] bcd;
    logic        neg;

    // Double-dabble helpers
    logic [39:0] bcd_adj;
    logic [3:0]  nib;

    // Glyph formation helpers
    logic [2:0]       msd;
    logic             ovf;
    logic [7:0][6:0]  glyph_nxt;

    // Display and scan state
    logic [7:0][6:0]  disp;
    logic [CNT_W-1:0] scan_cnt;
    logic [2:0]       idx;

    // Two's complement magnitude of the incoming word when it is a negative signed value
    logic        in_neg;
    logic [31:0] in_mag;

    assign in_neg  = SIGNED && value_i[31];
    assign in_mag  = in_neg ? (~value_i + 32'd1) : value_i;
    assign ready_o = (state == S_IDLE);
    assign DP      = 1'b1;

    // Add-3 correction on every BCD nibble that would overflow past 9 after doubling
    always_comb begin
        bcd_adj = bcd;
        nib     = 4'd0;
        for (int i = 0; i < 10; i++) begin
            nib = bcd[4*i +: 4];
            bcd_adj[4*i +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
        end
    end

    // Build the eight glyphs from the finished BCD: blanking, minus placement, overflow
    always_comb begin
        msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                msd = i[2:0];
            end
        end
        // A negative value needs one digit for the sign, so it overflows a digit earlier
        ovf = neg ? (bcd[39:28] != 12'd0) : (bcd[39:32] != 8'd0);
        glyph_nxt = '1;
        for (int i = 0; i < 8; i++) begin
            if (ovf) begin
                glyph_nxt[i] = SEG_MINUS;
            end else if (i == 0 || i <= int'(msd)) begin
                glyph_nxt[i] = seg_code(bcd[4*i +: 4]);
            end else if (neg && i == int'(msd) + 1) begin
                glyph_nxt[i] = SEG_MINUS;
            end else begin
                glyph_nxt[i] = SEG_BLANK;
            end
        end
    end

    // Converter FSM: capture, 32 shift iterations, then load the display register
    always_ff @(posedge CLK100) begin
        if (!resetn) begin
            state <= S_IDLE;
            iter  <= 5'd0;
            mag   <= 32'd0;
            bcd   <= 40'd0;
            neg   <= 1'b0;
            disp  <= {{7{SEG_BLANK}}, SEG_ZERO};
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        mag   <= in_mag;
                        neg   <= in_neg;
                        bcd   <= 40'd0;
                        iter  <= 5'd0;
                        state <= S_CONV;
                    end
                end
                S_CONV: begin
                    bcd  <= {bcd_adj[38:0], mag[31]};
                    mag  <= {mag[30:0], 1'b0};
                    iter <= iter + 5'd1;
                    if (iter == 5'd31) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    disp  <= glyph_nxt;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Free-running scan divider and digit index; never restarted by a display update
    always_ff @(posedge CLK100) begin
        if (!resetn) begin
            scan_cnt <= '0;
            idx      <= 3'd0;
        end else if (scan_cnt == CNT_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Anode and segment outputs registered together from the same index
    always_ff @(posedge CLK100) begin
        if (!resetn) begin
            AN  <= 8'hFF;
            SEG <= SEG_BLANK;
        end else begin
            AN  <= ~(8'd1 << idx);
            SEG <= disp[idx];
        end
    end

endmodule

// File: tb/tb_sevenseg_bcd_display.sv
// Directed bench for the BCD display: one signed and one unsigned instance, fast scan.
// Latency: checks 33-cycle busy window and display contents after each conversion.
// Backpressure: drives valid with and without holding it through the busy window.
module tb_sevenseg_bcd_display;

    logic        CLK100;
    logic        resetn;
    logic [31:0] value_a, value_b;
    logic        valid_a, valid_b;
    logic        ready_a, ready_b;
    logic [7:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;

    int checks = 0;
    int errors = 0;

    sevenseg_bcd_display #(.SCAN_DIV(4), .SIGNED(1'b1)) dut_s (
        .CLK100(CLK100), .resetn(resetn), .value_i(value_a), .valid_i(valid_a),
        .ready_o(ready_a), .AN(an_a), .SEG(seg_a), .DP(dp_a)
    );

    sevenseg_bcd_display #(.SCAN_DIV(4), .SIGNED(1'b0)) dut_u (
        .CLK100(CLK100), .resetn(resetn), .value_i(value_b), .valid_i(valid_b),
        .ready_o(ready_b), .AN(an_b), .SEG(seg_b), .DP(dp_b)
    );

    initial CLK100 = 1'b0;
    always #5 CLK100 = ~CLK100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected segment pattern for one display character
    function automatic logic [6:0] glyph(input byte c);
        case (c)
            "0": return 7'b0000001;
            "1": return 7'b1001111;
            "2": return 7'b0010010;
            "3": return 7'b0000110;
            "4": return 7'b1001100;
            "5": return 7'b0100100;
            "6": return 7'b0100000;
            "7": return 7'b0001111;
            "8": return 7'b0000000;
            "9": return 7'b0000100;
            "-": return 7'b1111110;
            default: return 7'b1111111;
        endcase
    endfunction

    // Watch 32 cycles (one full scan) and record the segments shown at each anode
    task automatic capture(input bit inst, output logic [7:0][6:0] g);
        logic [7:0] an;
        logic [6:0] seg;
        logic [7:0] sel;
        g = '0;
        for (int c = 0; c < 32; c++) begin
            @(negedge CLK100);
            an  = inst ? an_b : an_a;
            seg = inst ? seg_b : seg_a;
            for (int k = 0; k < 8; k++) begin
                sel = 8'd1 << k;
                if (an == ~sel) g[k] = seg;
            end
        end
    endtask

    // Compare a captured display against an 8-char string, leftmost char = digit 7
    task automatic check_display(input bit inst, input string tag, input string exp);
        logic [7:0][6:0] g;
        capture(inst, g);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_d%0d", tag, k), {25'd0, g[k]}, {25'd0, glyph(exp[7-k])});
        end
    endtask

    // Count negedges with ready low, bounded
    task automatic wait_ready(input bit inst, output int low);
        low = 0;
        for (int c = 0; c < 100; c++) begin
            if ((inst ? ready_b : ready_a) === 1'b1) break;
            low++;
            @(negedge CLK100);
        end
    endtask

    task automatic run_case(input bit inst, input logic [31:0] v, input string exp, input string tag);
        int low;
        @(negedge CLK100);
        check({tag, "_rdy_in"}, {31'd0, inst ? ready_b : ready_a}, 32'd1);
        if (inst) begin value_b = v; valid_b = 1'b1; end
        else      begin value_a = v; valid_a = 1'b1; end
        @(negedge CLK100);
        valid_a = 1'b0;
        valid_b = 1'b0;
        wait_ready(inst, low);
        check({tag, "_busy"}, low, 33);
        check_display(inst, tag, exp);
    endtask

    initial begin
        int low;
        logic [7:0] exp_an;
        resetn  = 1'b0;
        value_a = 32'd0;
        value_b = 32'd0;
        valid_a = 1'b0;
        valid_b = 1'b0;

        // Reset state
        repeat (3) @(negedge CLK100);
        check("rst_an", {24'd0, an_a}, 32'hFF);
        check("rst_seg", {25'd0, seg_a}, 32'h7F);
        check("rst_rdy", {31'd0, ready_a}, 32'd1);
        check("rst_dp", {31'd0, dp_a}, 32'd1);
        resetn = 1'b1;

        // Scan order: each anode held 4 cycles starting with digit 0
        for (int i = 0; i < 36; i++) begin
            @(negedge CLK100);
            exp_an = ~(8'd1 << ((i / 4) % 8));
            check($sformatf("scan_an%0d", i), {24'd0, an_a}, {24'd0, exp_an});
        end
        check_display(1'b0, "rst_disp", "       0");

        // Signed instance
        run_case(1'b0, 32'd1234,       "    1234", "v1234");
        run_case(1'b0, 32'hFFFFFFFB,   "      -5", "vneg5");
        run_case(1'b0, 32'h80000000,   "--------", "vmin");
        run_case(1'b0, 32'd1005,       "    1005", "v1005");
        run_case(1'b0, 32'hFF676981,   "-9999999", "vneg9999999");
        run_case(1'b0, 32'hFF676980,   "--------", "vneg10000000");

        // Unsigned instance
        run_case(1'b1, 32'd100000000,  "--------", "u1e8");
        run_case(1'b1, 32'd99999999,   "99999999", "u99999999");
        run_case(1'b1, 32'hFFFFFFFB,   "--------", "ubig");

        // valid held high, value changes during conversion
        @(negedge CLK100);
        value_a = 32'd7;
        valid_a = 1'b1;
        @(negedge CLK100);
        value_a = 32'd9;
        wait_ready(1'b0, low);
        check("hold_busy", low, 33);
        @(negedge CLK100);
        check("hold_reaccept", {31'd0, ready_a}, 32'd0);
        valid_a = 1'b0;
        check_display(1'b0, "hold_first", "       7");
        wait_ready(1'b0, low);
        check_display(1'b0, "hold_second", "       9");

        // Reset in the middle of a conversion
        @(negedge CLK100);
        value_a = 32'd55555;
        valid_a = 1'b1;
        @(negedge CLK100);
        valid_a = 1'b0;
        repeat (10) @(negedge CLK100);
        resetn = 1'b0;
        @(negedge CLK100);
        check("midrst_an", {24'd0, an_a}, 32'hFF);
        check("midrst_rdy", {31'd0, ready_a}, 32'd1);
        resetn = 1'b1;
        repeat (40) @(negedge CLK100);
        check("midrst_rdy2", {31'd0, ready_a}, 32'd1);
        check_display(1'b0, "midrst", "       0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
